// File: rtl/gated_event_mon.sv
// Per-channel gated edge monitor: IDLE/ARMED/FIRED FSM, qualified-event counter and hit pulse.
// Define GATED_EVENT_MON_SAT_EN to make counters saturate instead of wrapping.
module gated_event_mon #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       sig_i,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic [2*CHANNELS-1:0]     mode_i,
    input  logic [CHANNELS-1:0]       oneshot_i,
    input  logic [CHANNELS-1:0]       arm_i,
    input  logic [CHANNELS-1:0]       clr_i,
    output logic [CHANNELS-1:0]       hit_o,
    output logic [CHANNELS-1:0]       fired_o,
    output logic [CHANNELS*CNT_W-1:0] count_o,
    output logic                      any_hit_o,
    output logic [2*CHANNELS-1:0]     state_dbg_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

    state_t             r_state     [CHANNELS];
    state_t             w_state_nxt [CHANNELS];
    logic [CNT_W-1:0]   r_count     [CHANNELS];
    logic [CNT_W-1:0]   w_count_nxt [CHANNELS];
    logic [CHANNELS-1:0] r_sig_q;
    logic [CHANNELS-1:0] r_hit;
    logic [CHANNELS-1:0] w_edge;
    logic [CHANNELS-1:0] w_qual;

    // After reset every channel is IDLE, so the first sample can never count;
    // no separate "primed" flag is needed to mask the reset value of r_sig_q.
    always_comb begin
        w_edge = '0;
        w_qual = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            case (mode_i[2*ch +: 2])
                2'b01:   w_edge[ch] = sig_i[ch] & ~r_sig_q[ch];
                2'b10:   w_edge[ch] = ~sig_i[ch] & r_sig_q[ch];
                2'b11:   w_edge[ch] = sig_i[ch] ^ r_sig_q[ch];
                default: w_edge[ch] = 1'b0;
            endcase
            w_qual[ch] = w_edge[ch] & en_i[ch] & ~clr_i[ch] & (r_state[ch] == ST_ARMED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_state[ch] <= ST_IDLE;
                r_count[ch] <= '0;
            end
            r_sig_q <= '0;
            r_hit   <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_state[ch] <= w_state_nxt[ch];
                r_count[ch] <= w_count_nxt[ch];
            end
            r_sig_q <= sig_i;
            r_hit   <= w_qual;
        end
    end

    // Clear dominates arm and any same-cycle event.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_state_nxt[ch] = r_state[ch];
            if (clr_i[ch]) begin
                w_state_nxt[ch] = ST_IDLE;
            end else begin
                case (r_state[ch])
                    ST_IDLE:  if (arm_i[ch]) w_state_nxt[ch] = ST_ARMED;
                    ST_ARMED: if (w_qual[ch] && oneshot_i[ch]) w_state_nxt[ch] = ST_FIRED;
                    ST_FIRED: w_state_nxt[ch] = ST_FIRED;
                    default:  w_state_nxt[ch] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_count_nxt[ch] = r_count[ch];
            if (clr_i[ch]) begin
                w_count_nxt[ch] = '0;
            end else if (w_qual[ch]) begin
`ifdef GATED_EVENT_MON_SAT_EN
                if (!(&r_count[ch])) w_count_nxt[ch] = r_count[ch] + 1'b1;
`else
                w_count_nxt[ch] = r_count[ch] + 1'b1;
`endif
            end
        end
    end

    always_comb begin
        count_o     = '0;
        fired_o     = '0;
        state_dbg_o = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            count_o[ch*CNT_W +: CNT_W] = r_count[ch];
            fired_o[ch]                = (r_state[ch] == ST_FIRED);
            state_dbg_o[2*ch +: 2]     = r_state[ch];
        end
        hit_o     = r_hit;
        any_hit_o = |r_hit;
    end

endmodule

// File: tb/tb_gated_event_mon.sv
// Bench for gated_event_mon: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_gated_event_mon;

    localparam int CH   = 4;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic [CH-1:0]   sig     = '0;
    logic [CH-1:0]   en      = '0;
    logic [2*CH-1:0] mode    = '0;
    logic [CH-1:0]   oneshot = '0;
    logic [CH-1:0]   arm     = '0;
    logic [CH-1:0]   clr     = '0;
    logic [CH-1:0]   hit_o;
    logic [CH-1:0]   fired_o;
    logic [CH*CW-1:0] count_o;
    logic            any_hit_o;
    logic [2*CH-1:0] state_dbg_o;

    int n_checks = 0;
    int n_errors = 0;

    gated_event_mon #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sig_i(sig), .en_i(en), .mode_i(mode),
        .oneshot_i(oneshot), .arm_i(arm), .clr_i(clr), .hit_o(hit_o),
        .fired_o(fired_o), .count_o(count_o), .any_hit_o(any_hit_o),
        .state_dbg_o(state_dbg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: what each channel must show after every clock edge.
    bit          m_armed [CH];
    bit          m_fired [CH];
    int          m_cnt   [CH];
    bit [CH-1:0] m_hit = '0;
    bit [CH-1:0] m_sig = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_armed[c] <= 1'b0;
                m_fired[c] <= 1'b0;
                m_cnt[c]   <= 0;
            end
            m_hit <= '0;
            m_sig <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                bit rise, fall, seen, qual;
                int nc;
                rise = sig[c] && !m_sig[c];
                fall = !sig[c] && m_sig[c];
                seen = (mode[2*c +: 2] == 2'b01 && rise) || (mode[2*c +: 2] == 2'b10 && fall) ||
                       (mode[2*c +: 2] == 2'b11 && (rise || fall));
                qual = seen && en[c] && m_armed[c] && !clr[c];
                m_hit[c] <= qual;
`ifdef GATED_EVENT_MON_SAT_EN
                nc = (m_cnt[c] < MAXC) ? m_cnt[c] + 1 : MAXC;
`else
                nc = (m_cnt[c] + 1) % (MAXC + 1);
`endif
                if (clr[c]) begin
                    m_armed[c] <= 1'b0;
                    m_fired[c] <= 1'b0;
                    m_cnt[c]   <= 0;
                end else if (qual) begin
                    m_cnt[c] <= nc;
                    if (oneshot[c]) begin
                        m_armed[c] <= 1'b0;
                        m_fired[c] <= 1'b1;
                    end
                end else if (arm[c] && !m_armed[c] && !m_fired[c]) begin
                    m_armed[c] <= 1'b1;
                end
                m_sig[c] <= sig[c];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("model_hit[%0d]", c), hit_o[c], m_hit[c]);
            chk($sformatf("model_fired[%0d]", c), fired_o[c], m_fired[c]);
            chk($sformatf("model_count[%0d]", c), count_o[c*CW +: CW], m_cnt[c]);
            chk($sformatf("model_state[%0d]", c), state_dbg_o[2*c +: 2],
                m_fired[c] ? 2 : (m_armed[c] ? 1 : 0));
        end
        chk("model_any_hit", any_hit_o, |m_hit);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        mode    = 8'b01_11_10_01;
        en      = 4'b1111;
        oneshot = 4'b0010;
        sig     = 4'b0001;
        tick(2);
        chk("reset_count", count_o, 0);
        chk("reset_hit", hit_o, 0);
        chk("reset_fired", fired_o, 0);
        chk("reset_state", state_dbg_o, 0);

        // Signal already high at reset release is not a posedge.
        rst_n = 1'b1;
        arm   = 4'b0001;
        tick(1);
        arm = '0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("high_at_reset_hit0", hit_o[0], 0);
        end
        chk("high_at_reset_count0", count_o[1:0], 0);
        chk("high_at_reset_armed0", state_dbg_o[1:0], 1);

        // Enable qualifies only the fourth rising edge.
        for (int p = 1; p <= 4; p++) begin
            sig[0] = 1'b0;
            en[0]  = 1'b0;
            tick(1);
            sig[0] = 1'b1;
            en[0]  = (p == 4);
            tick(1);
            chk($sformatf("gated_hit0_p%0d", p), hit_o[0], (p == 4));
        end
        tick(1);
        chk("gated_hit0_gone", hit_o[0], 0);
        chk("gated_count0", count_o[1:0], 1);

        // Mode off keeps tracking the signal, so re-enabling gives no stale edge.
        mode[1:0] = 2'b00;
        sig[0]    = 1'b0;
        tick(1);
        sig[0] = 1'b1;
        tick(1);
        chk("mode_off_hit0", hit_o[0], 0);
        mode[1:0] = 2'b01;
        tick(1);
        chk("mode_reenable_hit0", hit_o[0], 0);
        sig[0] = 1'b0;
        tick(1);
        sig[0] = 1'b1;
        tick(1);
        chk("mode_reenable_rise_hit0", hit_o[0], 1);
        chk("mode_reenable_count0", count_o[1:0], 2);

        // One-shot negedge channel.
        arm[1] = 1'b1;
        sig[1] = 1'b1;
        tick(1);
        arm[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sig[1] = 1'b0;
            tick(1);
            chk($sformatf("oneshot_hit1_f%0d", k), hit_o[1], (k == 0));
            if (k == 0) chk("oneshot_fired_with_hit", fired_o[1], 1);
            sig[1] = 1'b1;
            tick(1);
        end
        chk("oneshot_fired1", fired_o[1], 1);
        chk("oneshot_count1", count_o[3:2], 1);
        clr[1] = 1'b1;
        tick(1);
        clr[1] = 1'b0;
        chk("clr_fired1", fired_o[1], 0);
        chk("clr_count1", count_o[3:2], 0);
        chk("clr_state1", state_dbg_o[3:2], 0);

        // Any-edge continuous channel, six toggles.
        arm[2] = 1'b1;
        tick(1);
        arm[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sig[2] = ~sig[2];
            tick(1);
            chk($sformatf("toggle_hit2_%0d", i), hit_o[2], 1);
        end
`ifdef GATED_EVENT_MON_SAT_EN
        chk("toggle_count2", count_o[5:4], 3);
`else
        chk("toggle_count2", count_o[5:4], 2);
`endif

        // Clear beats arm and a same-cycle edge.
        arm[3] = 1'b1;
        tick(1);
        arm[3] = 1'b0;
        sig[3] = 1'b1;
        tick(1);
        chk("prio_pre_hit3", hit_o[3], 1);
        chk("prio_pre_count3", count_o[7:6], 1);
        sig[3] = 1'b0;
        tick(1);
        clr[3] = 1'b1;
        arm[3] = 1'b1;
        sig[3] = 1'b1;
        tick(1);
        chk("prio_hit3", hit_o[3], 0);
        chk("prio_count3", count_o[7:6], 0);
        chk("prio_state3", state_dbg_o[7:6], 0);
        clr[3] = 1'b0;
        sig[3] = 1'b0;
        tick(1);
        arm[3] = 1'b0;
        sig[3] = 1'b1;
        tick(1);
        chk("rearm_hit3", hit_o[3], 1);
        chk("rearm_count3", count_o[7:6], 1);

        // Simultaneous edges on every channel.
        oneshot = '0;
        arm[1]  = 1'b1;
        sig     = 4'b0010;
        tick(1);
        arm[1] = 1'b0;
        tick(1);
        sig = 4'b1101;
        tick(1);
        chk("all_hit", hit_o, 4'b1111);
        chk("all_any_hit", any_hit_o, 1);
        tick(1);
        chk("all_hit_gone", hit_o, 0);
        chk("all_any_gone", any_hit_o, 0);

        // Asynchronous reset away from the clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", count_o, 0);
        chk("async_rst_state", state_dbg_o, 0);
        chk("async_rst_fired", fired_o, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gated_event_mon.md
GATED_EVENT_MON -- requirements
Module: gated_event_mon

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent monitored channels (1..32).
REQ-002 Parameter CNT_W, default 8, width of each per-channel event counter (2..16).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sig_i  input  CHANNELS  monitored signals, one bit per channel, synchronous to clk.
REQ-006 en_i  input  CHANNELS  per-channel qualifier; event counts only if en_i[ch]=1 in the cycle the edge is seen (&&& semantics).
REQ-007 mode_i  input  2*CHANNELS  per-channel edge select, bits [2ch+1:2ch]: 00 off, 01 posedge, 10 negedge, 11 any edge.
REQ-008 oneshot_i  input  CHANNELS  1 = channel stops after first qualified event; 0 = continuous counting.
REQ-009 arm_i  input  CHANNELS  one-cycle arm request per channel.
REQ-010 clr_i  input  CHANNELS  one-cycle clear request per channel.
REQ-011 hit_o  output  CHANNELS  one-cycle pulse per qualified event.
REQ-012 fired_o  output  CHANNELS  level, high while channel in FIRED.
REQ-013 count_o  output  CHANNELS*CNT_W  per-channel qualified-event count, channel ch at [ch*CNT_W +: CNT_W].
REQ-014 any_hit_o  output  1  OR of hit_o.

Function
REQ-015 Each channel SHALL register previous sample sig_q[ch]; edge detected in cycle when sig_i[ch] differs from sig_q[ch] and matches mode (rise: 0->1, fall: 1->0).
REQ-016 Qualified event = edge detected AND en_i[ch]=1 AND channel in ARMED, all sampled at the same clk edge.
REQ-017 Per-channel FSM states IDLE, ARMED, FIRED; IDLE->ARMED on arm_i; ARMED->FIRED on qualified event when oneshot_i=1; ARMED stays ARMED on qualified event when oneshot_i=0; any state->IDLE on clr_i.
REQ-018 Arm in ARMED or FIRED SHALL have no effect; re-arm from FIRED requires clr_i first.
REQ-019 clr_i SHALL take priority over arm_i and over a same-cycle event: state IDLE, count 0, no hit.
REQ-020 Edge in the same cycle as arm_i from IDLE SHALL NOT be counted.
REQ-021 Qualified event SHALL increment count_o[ch] by 1 and assert hit_o[ch] for exactly the next cycle (latency 1 clk from the sampling edge).
REQ-022 Mode 00 SHALL suppress detection; sig_q SHALL still update every cycle so re-enabling a mode never produces a stale edge.
REQ-023 Changing mode_i, en_i or oneshot_i SHALL take effect on the next sampling edge without other side effect.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels all count.
REQ-025 fired_o[ch] SHALL be registered and rise in the same cycle as the corresponding hit_o[ch].

Reset
REQ-026 On rst_n=0: all states IDLE, counts 0, hit_o 0, fired_o 0, any_hit_o 0, sig_q 0.
REQ-027 First clk edge after reset release SHALL load sig_q without edge detection (a signal already high is not a posedge).
REQ-028 Reset asserted mid-operation SHALL clear all state immediately, independent of clk.

Configuration
REQ-029 Macro GATED_EVENT_MON_SAT_EN defined: counters saturate at 2**CNT_W-1; further qualified events still pulse hit_o.
REQ-030 Macro undefined: counters wrap from 2**CNT_W-1 to 0.

Verification
REQ-031 Reset with sig_i[0]=1, mode 01, arm ch0, en=1, hold sig high 5 cycles -> no hit, count 0.
REQ-032 Ch0 mode 01, armed, en_i[0] low for pulses 1-3 and high for pulse 4 -> single hit_o[0] one cycle after pulse 4 rise, count_o 1.
REQ-033 Ch1 mode 10, oneshot=1, armed, en=1, three falling edges -> one hit, fired_o[1]=1, count 1; clr_i -> IDLE, count 0, fired 0.
REQ-034 Ch2 mode 11, continuous, CNT_W=2, 6 toggles with en=1 -> count 3 with SAT_EN, count 2 without; 6 hit pulses either way.
REQ-035 Same cycle: clr_i[3], arm_i[3] and qualified edge on ch3 -> state IDLE, count 0, no hit; arm next cycle, edge -> count 1.
REQ-036 Edges on all 4 channels same cycle, all armed and enabled -> hit_o=4'b1111 and any_hit_o=1 for one cycle.
